// File: rtl/knight_pkg.sv
// Shared types and constants for the knight player controller.
// Status encoding, USB keycodes and sprite dimensions live here.
package knight_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_WALK = 4'd1,
        ST_JUMP = 4'd2,
        ST_FALL = 4'd3
    } status_t;

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [9:0] SPRITE_SIZE_X = 10'd50;
    localparam logic [9:0] SPRITE_SIZE_Y = 10'd64;

    // True when either keycode slot holds the requested key.
    function automatic logic key_hit(input logic [7:0] k0,
                                     input logic [7:0] k1,
                                     input logic [7:0] key);
        return (k0 == key) || (k1 == key);
    endfunction

endpackage

// File: rtl/knight_key_decode.sv
// Combinational keycode decoder: either keycode slot may carry any key.
module knight_key_decode
    import knight_pkg::*;
(
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic       left,
    output logic       right,
    output logic       jump
);

    assign left  = key_hit(keycode0, keycode1, KEY_A);
    assign right = key_hit(keycode0, keycode1, KEY_D);
    assign jump  = key_hit(keycode0, keycode1, KEY_W) |
                   key_hit(keycode0, keycode1, KEY_SPACE);

endmodule

// File: rtl/knight_motion.sv
// Per-frame knight controller: idle/walk/jump/fall FSM with integer gravity,
// horizontal air control and facing; all outputs registered on frame_clk.
module knight_motion
    import knight_pkg::*;
#(
    parameter int X_START   = 320,
    parameter int GROUND_Y  = 400,
    parameter int X_MIN     = 25,
    parameter int X_MAX     = 614,
    parameter int Y_MIN     = 32,
    parameter int WALK_STEP = 3,
    parameter int JUMP_V    = -12,
    parameter int GRAV      = 1,
    parameter int VMAX      = 10
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [9:0] Player_X,
    output logic [9:0] Player_Y,
    output logic [9:0] Player_SizeX,
    output logic [9:0] Player_SizeY,
    output logic [3:0] Player_Status,
    output logic       Inverse
);

    localparam logic [9:0] X_START_U = 10'(X_START);
    localparam logic [9:0] GROUND_U  = 10'(GROUND_Y);
    localparam logic [9:0] X_MIN_U   = 10'(X_MIN);
    localparam logic [9:0] X_MAX_U   = 10'(X_MAX);
    localparam logic [9:0] Y_MIN_U   = 10'(Y_MIN);

    localparam logic signed [11:0] X_MIN_S  = 12'(X_MIN);
    localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
    localparam logic signed [11:0] STEP_S   = 12'(WALK_STEP);
    localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
    localparam logic signed [10:0] Y_MIN_S  = 11'(Y_MIN);
    localparam logic signed [7:0]  JUMP_V_S = 8'(JUMP_V);
    localparam logic signed [7:0]  GRAV_S   = 8'(GRAV);
    localparam logic signed [7:0]  VMAX_S   = 8'(VMAX);

    status_t            state_r, next_state_s;
    logic [9:0]         x_r, y_r, next_x_s, next_y_s;
    logic [9:0]         size_x_r, size_y_r;
    logic signed [7:0]  vy_r, next_vy_s, vy_inc_s;
    logic               inv_r, next_inv_s, jump_prev_r;
    logic               left_s, right_s, jump_s, dir_s, jump_edge_s;
    logic signed [11:0] x_ext_s, x_left_s, x_right_s;
    logic signed [10:0] y_sum_s;

    knight_key_decode u_decode (
        .keycode0 (keycode0),
        .keycode1 (keycode1),
        .left     (left_s),
        .right    (right_s),
        .jump     (jump_s)
    );

    assign dir_s       = left_s ^ right_s;
    assign jump_edge_s = jump_s & ~jump_prev_r;

    // Wide signed intermediates so saturation sees the true overshoot.
    assign x_ext_s   = signed'({2'b00, x_r});
    assign x_left_s  = x_ext_s - STEP_S;
    assign x_right_s = x_ext_s + STEP_S;
    assign y_sum_s   = signed'({1'b0, y_r}) + signed'({{3{vy_r[7]}}, vy_r});
    assign vy_inc_s  = vy_r + GRAV_S;

    // Horizontal motion and facing; active in every state.
    always_comb begin
        next_x_s   = x_r;
        next_inv_s = inv_r;
        if (left_s && !right_s) begin
            next_inv_s = 1'b1;
            if (x_left_s < X_MIN_S) begin
                next_x_s = X_MIN_U;
            end else begin
                next_x_s = x_left_s[9:0];
            end
        end else if (right_s && !left_s) begin
            next_inv_s = 1'b0;
            if (x_right_s > X_MAX_S) begin
                next_x_s = X_MAX_U;
            end else begin
                next_x_s = x_right_s[9:0];
            end
        end else begin
            next_x_s   = x_r;
            next_inv_s = inv_r;
        end
    end

    // Next-state, vertical position and velocity.
    always_comb begin
        next_state_s = state_r;
        next_y_s     = y_r;
        next_vy_s    = vy_r;
        case (state_r)
            ST_IDLE: begin
                if (jump_edge_s) begin
                    next_state_s = ST_JUMP;
                    next_vy_s    = JUMP_V_S;
                end else if (dir_s) begin
                    next_state_s = ST_WALK;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WALK: begin
                if (jump_edge_s) begin
                    next_state_s = ST_JUMP;
                    next_vy_s    = JUMP_V_S;
                end else if (!dir_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WALK;
                end
            end
            ST_JUMP: begin
                if (y_sum_s < Y_MIN_S) begin
                    next_y_s     = Y_MIN_U;
                    next_vy_s    = 8'sd0;
                    next_state_s = ST_FALL;
                end else begin
                    next_y_s  = y_sum_s[9:0];
                    next_vy_s = vy_inc_s;
                    if (vy_inc_s >= 8'sd0) begin
                        next_state_s = ST_FALL;
                    end else begin
                        next_state_s = ST_JUMP;
                    end
                end
            end
            ST_FALL: begin
                // Landing clamps Y and leaves the air on the same edge.
                if (y_sum_s >= GROUND_S) begin
                    next_y_s     = GROUND_U;
                    next_vy_s    = 8'sd0;
                    next_state_s = dir_s ? ST_WALK : ST_IDLE;
                end else begin
                    next_y_s     = y_sum_s[9:0];
                    next_vy_s    = (vy_inc_s > VMAX_S) ? VMAX_S : vy_inc_s;
                    next_state_s = ST_FALL;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_y_s     = GROUND_U;
                next_vy_s    = 8'sd0;
            end
        endcase
    end

    // Frame register with synchronous reset.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            x_r         <= X_START_U;
            y_r         <= GROUND_U;
            vy_r        <= 8'sd0;
            inv_r       <= 1'b0;
            jump_prev_r <= 1'b0;
            size_x_r    <= SPRITE_SIZE_X;
            size_y_r    <= SPRITE_SIZE_Y;
        end else begin
            state_r     <= next_state_s;
            x_r         <= next_x_s;
            y_r         <= next_y_s;
            vy_r        <= next_vy_s;
            inv_r       <= next_inv_s;
            jump_prev_r <= jump_s;
            size_x_r    <= SPRITE_SIZE_X;
            size_y_r    <= SPRITE_SIZE_Y;
        end
    end

    assign Player_X      = x_r;
    assign Player_Y      = y_r;
    assign Player_SizeX  = size_x_r;
    assign Player_SizeY  = size_y_r;
    assign Player_Status = state_r;
    assign Inverse       = inv_r;

endmodule
